// File: rtl/montgomery_modexp_ctrl.sv
// montgomery_modexp_ctrl
//   Sequences one shared Montgomery multiplier core through left-to-right
//   square-and-multiply to compute X^E mod M from pre-mapped operands
//   (in_xm = X*R mod M, in_rm = R mod M, R = 2^WIDTH).
// Ports:
//   clk, resetn (sync, active-low)
//   start, in_xm, in_rm, in_m, in_e, in_e_len   : request (sampled in IDLE only)
//   busy, done, result                          : status / final value
//   mont_start, mont_a, mont_b, mont_m          : core command side
//   mont_done, mont_result                      : core completion side
// Build option: define MODEXP_FINAL_CONV_EN to add a final multiply-by-1
//   that maps the result back out of the Montgomery domain. Without it the
//   result stays in the Montgomery domain (X^E*R mod M) for chaining.
module montgomery_modexp_ctrl #(
  parameter int WIDTH     = 512,
  parameter int EXP_WIDTH = 512,
  parameter int IDX_W     = $clog2(EXP_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_xm,
  input  logic [WIDTH-1:0]     in_rm,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [IDX_W-1:0]     in_e_len,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 mont_start,
  output logic [WIDTH-1:0]     mont_a,
  output logic [WIDTH-1:0]     mont_b,
  output logic [WIDTH-1:0]     mont_m,
  input  logic                 mont_done,
  input  logic [WIDTH-1:0]     mont_result
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_SQ,
    S_SQ_WAIT,
    S_MUL,
    S_MUL_WAIT,
`ifdef MODEXP_FINAL_CONV_EN
    S_CONV,
    S_CONV_WAIT,
`endif
    S_DONE
  } state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     xm_q;
  logic [EXP_WIDTH-1:0] e_q;
  logic [WIDTH-1:0]     acc;
  logic [IDX_W-1:0]     idx;
  logic                 e_bit;

  localparam logic [IDX_W-1:0] EXP_MAX = IDX_W'(EXP_WIDTH);

  // Exponent bit for the current position; idx has already been decremented
  // in CHECK, so it points at the bit being processed. A mask-and-reduce
  // avoids a part-select whose index is wider than the exponent needs.
  assign e_bit = |(e_q & (EXP_WIDTH'(1) << idx));

  always_comb begin
    state_nxt  = state;
    mont_start = 1'b0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE:     if (start) state_nxt = S_CHECK;
      S_CHECK: begin
        if (idx == '0) begin
`ifdef MODEXP_FINAL_CONV_EN
          state_nxt = S_CONV;
`else
          state_nxt = S_DONE;
`endif
        end else begin
          state_nxt = S_SQ;
        end
      end
      S_SQ: begin
        mont_start = 1'b1;
        state_nxt  = S_SQ_WAIT;
      end
      S_SQ_WAIT:  if (mont_done) state_nxt = e_bit ? S_MUL : S_CHECK;
      S_MUL: begin
        mont_start = 1'b1;
        state_nxt  = S_MUL_WAIT;
      end
      S_MUL_WAIT: if (mont_done) state_nxt = S_CHECK;
`ifdef MODEXP_FINAL_CONV_EN
      S_CONV: begin
        mont_start = 1'b1;
        state_nxt  = S_CONV_WAIT;
      end
      S_CONV_WAIT: if (mont_done) state_nxt = S_DONE;
`endif
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Core operands are loaded on the transition into the issuing state so
  // they are already valid in the mont_start cycle and then held untouched
  // until the matching mont_done. result is loaded on entry to DONE so it is
  // valid in the same cycle as the done pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= S_IDLE;
      xm_q   <= '0;
      e_q    <= '0;
      acc    <= '0;
      idx    <= '0;
      result <= '0;
      mont_a <= '0;
      mont_b <= '0;
      mont_m <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            xm_q   <= in_xm;
            e_q    <= in_e;
            mont_m <= in_m;
            acc    <= in_rm;
            idx    <= (in_e_len > EXP_MAX) ? EXP_MAX : in_e_len;
          end
        end
        S_CHECK: begin
          if (idx != '0) begin
            idx    <= idx - 1'b1;
            mont_a <= acc;
            mont_b <= acc;
          end else begin
`ifdef MODEXP_FINAL_CONV_EN
            mont_a <= acc;
            mont_b <= WIDTH'(1);
`else
            result <= acc;
`endif
          end
        end
        S_SQ_WAIT: begin
          if (mont_done) begin
            acc <= mont_result;
            if (e_bit) begin
              mont_a <= mont_result;
              mont_b <= xm_q;
            end
          end
        end
        S_MUL_WAIT: if (mont_done) acc <= mont_result;
`ifdef MODEXP_FINAL_CONV_EN
        S_CONV_WAIT: begin
          if (mont_done) begin
            acc    <= mont_result;
            result <= mont_result;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_modexp_ctrl.sv
module tb_montgomery_modexp_ctrl;

  localparam int W    = 8;
  localparam int EW   = 8;
  localparam int IW   = $clog2(EW + 1);
  localparam int MOD  = 13;
  localparam int RINV = 3;   // 256^-1 mod 13 (256 mod 13 = 9, 9*3 = 27 = 1)
`ifdef MODEXP_FINAL_CONV_EN
  localparam int CONV = 1;
`else
  localparam int CONV = 0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  in_xm = '0, in_rm = '0, in_m = '0;
  logic [EW-1:0] in_e = '0;
  logic [IW-1:0] in_e_len = '0;
  logic          busy, done, mont_start;
  logic [W-1:0]  result, mont_a, mont_b, mont_m;
  logic          core_done = 1'b0, spur_done = 1'b0, mont_done;
  logic [W-1:0]  mont_result = '0;

  assign mont_done = core_done | spur_done;

  int n_cmp = 0, n_bad = 0;
  int op_cnt = 0;
  int lat_min = 1, lat_max = 3;

  always #5 clk = ~clk;

  montgomery_modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .in_xm(in_xm), .in_rm(in_rm), .in_m(in_m), .in_e(in_e), .in_e_len(in_e_len),
    .busy(busy), .done(done), .result(result),
    .mont_start(mont_start), .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m),
    .mont_done(mont_done), .mont_result(mont_result)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mont_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int p;
    p = (int'(a) * int'(b) * RINV) % MOD;
    return p[W-1:0];
  endfunction

  // Behavioural core: captures operands on mont_start, checks they stay put
  // for the whole (random) latency, then pulses done with a*b*R^-1 mod M.
  logic [W-1:0] ca, cb;
  int           lat, cnt;
  bit           ab;
  initial begin
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (resetn && mont_start) begin
        ca = mont_a;
        cb = mont_b;
        op_cnt++;
        lat = int'($urandom_range(lat_max, lat_min));
        cnt = 0;
        ab  = 1'b0;
        while (cnt < lat && !ab) begin
          @(negedge clk);
          if (!resetn) ab = 1'b1;
          else begin
            chk("mont_a_stable", int'(mont_a), int'(ca));
            chk("mont_b_stable", int'(mont_b), int'(cb));
            chk("mont_start_one_cycle", int'(mont_start), 0);
            cnt++;
          end
        end
        if (!ab) begin
          core_done   = 1'b1;
          mont_result = mont_mul(ca, cb);
        end
      end
    end
  end

  // noisy: re-assert start with junk operands while busy and inject a
  // spurious mont_done in the first SQ cycle; both must be ignored.
  task automatic run_op(input string tag, input logic [W-1:0] xm, input logic [EW-1:0] e,
                        input logic [IW-1:0] len, input int exp_res, input int exp_ops,
                        input bit noisy);
    int  cyc, base;
    bit  seen, spur_sent;
    @(negedge clk);
    in_xm = xm; in_e = e; in_e_len = len; start = 1'b1;
    base = op_cnt;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, int'(busy), 1);
    if (noisy) begin
      start = 1'b1; in_xm = 8'd1; in_e = 8'h00; in_e_len = 4'd0;
    end
    seen = 1'b0; spur_sent = 1'b0; cyc = 0;
    while (!seen && cyc < 4000) begin
      if (done) seen = 1'b1;
      else begin
        if (noisy && mont_start && !spur_sent) begin
          spur_done = 1'b1;
          spur_sent = 1'b1;
        end
        @(negedge clk);
        spur_done = 1'b0;
        cyc++;
      end
    end
    start = 1'b0;
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: no done within %0d cycles", tag, cyc);
    end else begin
      chk({tag, "_result"}, int'(result), exp_res);
      chk({tag, "_ops"}, op_cnt - base, exp_ops);
      chk({tag, "_mont_m"}, int'(mont_m), MOD);
      @(negedge clk);
      chk({tag, "_done_width"}, int'(done), 0);
      chk({tag, "_busy_clear"}, int'(busy), 0);
      chk({tag, "_result_held"}, int'(result), exp_res);
    end
  endtask

  typedef struct {
    logic [W-1:0]  xm;
    logic [EW-1:0] e;
    logic [IW-1:0] len;
    int            res_conv;   // X^E mod 13
    int            res_mont;   // X^E * 256 mod 13
    int            ops;        // e_len + popcount, without the conversion
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    int cyc;
    vecs[0] = '{8'd6, 8'h0B, 4'd4,  8,  7,  7};  // 5^11
    vecs[1] = '{8'd6, 8'hFF, 4'd0,  1,  9,  0};  // e_len=0
    vecs[2] = '{8'd6, 8'hFF, 4'd3,  8,  7,  6};  // 5^7, upper bits ignored
    vecs[3] = '{8'd6, 8'h00, 4'd4,  1,  9,  4};  // squares only
    vecs[4] = '{8'd6, 8'h01, 4'd1,  5,  6,  2};  // 5^1
    vecs[5] = '{8'd6, 8'h02, 4'd2, 12,  4,  3};  // 5^2
    vecs[6] = '{8'd6, 8'h81, 4'd12, 5,  6, 10};  // e_len clamped to 8: 5^129
    vecs[7] = '{8'd5, 8'h0A, 4'd4, 10, 12,  6};  // 2^10

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_mont_start", int'(mont_start), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_mont_a", int'(mont_a), 0);
    chk("rst_mont_b", int'(mont_b), 0);
    chk("rst_mont_m", int'(mont_m), 0);
    resetn = 1'b1;
    in_rm = 8'd9;
    in_m  = 8'd13;

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].xm, vecs[i].e, vecs[i].len,
             CONV ? vecs[i].res_conv : vecs[i].res_mont, vecs[i].ops + CONV, 1'b0);

    // start during busy and a spurious mont_done in SQ
    run_op("noisy", vecs[0].xm, vecs[0].e, vecs[0].len,
           CONV ? vecs[0].res_conv : vecs[0].res_mont, vecs[0].ops + CONV, 1'b1);

    // reset while the first multiply (second core op) is outstanding
    lat_min = 10; lat_max = 10;
    @(negedge clk);
    in_xm = vecs[0].xm; in_e = vecs[0].e; in_e_len = vecs[0].len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 1000) begin
      if (mont_start) n++;
      if (n < 2) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (n < 2) begin
      n_cmp++; n_bad++;
      $display("FAIL abort_reach_mul: saw %0d core starts, needed 2", n);
    end
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_mont_start", int'(mont_start), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    resetn = 1'b1;
    lat_min = 1; lat_max = 3;
    run_op("after_abort", vecs[0].xm, vecs[0].e, vecs[0].len,
           CONV ? vecs[0].res_conv : vecs[0].res_mont, vecs[0].ops + CONV, 1'b0);

    // long and varied core latency
    lat_min = 1; lat_max = 40;
    run_op("lat_vec0", vecs[0].xm, vecs[0].e, vecs[0].len,
           CONV ? vecs[0].res_conv : vecs[0].res_mont, vecs[0].ops + CONV, 1'b0);
    run_op("lat_vec2", vecs[2].xm, vecs[2].e, vecs[2].len,
           CONV ? vecs[2].res_conv : vecs[2].res_mont, vecs[2].ops + CONV, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
